// File: rtl/exc_pkg.sv
// Shared cause codes, controller states and default bounds for the exception controller.
package exc_pkg;

    typedef enum logic [2:0] {
        CauseNone      = 3'd0,
        CauseSpOver    = 3'd1,
        CauseSpUnder   = 3'd2,
        CauseIllegalOp = 3'd3,
        CauseDivZero   = 3'd4,
        CauseImemFault = 3'd5,
        CauseDmemFault = 3'd6,
        CauseDouble    = 3'd7
    } cause_e;

    typedef enum logic [2:0] {StIdle, StFlush, StVector, StHandler, StReturn, StHalt} state_e;

    typedef enum logic [1:0] {StageNone, StageId, StageEx, StageMem} stage_e;

    localparam int unsigned DefSpMin      = 2047;
    localparam int unsigned DefSpMax      = 4095;
    localparam int unsigned DefImemMax    = 1048575;
    localparam int unsigned DefDmemMax    = 4095;
    localparam int unsigned DefMaxOpcode  = 11;
    localparam int unsigned DefDivOp      = 10;
    localparam int unsigned DefFlushCycles = 3;
    localparam int unsigned DefHandlerStride = 16;

    // Flush vector is {mem, ex, id}: the faulting stage and every younger one.
    function automatic logic [2:0] stage_flush(stage_e stage);
        logic [2:0] fl;
        unique case (stage)
            StageMem: fl = 3'b111;
            StageEx:  fl = 3'b011;
            StageId:  fl = 3'b001;
            default:  fl = 3'b000;
        endcase
        return fl;
    endfunction

endpackage

// File: rtl/exc_detect.sv
// Combinational fault detection, mask qualification and oldest-stage-first priority selection.
module exc_detect
    import exc_pkg::*;
#(
    parameter int          DATA_W     = 16,
    parameter int          ADDR_W     = 32,
    parameter int unsigned SP_MIN     = DefSpMin,
    parameter int unsigned SP_MAX     = DefSpMax,
    parameter int unsigned IMEM_MAX   = DefImemMax,
    parameter int unsigned DMEM_MAX   = DefDmemMax,
    parameter int unsigned MAX_OPCODE = DefMaxOpcode,
    parameter int unsigned DIV_OP     = DefDivOp
) (
    input  logic [3:0]        id_opcode_i,
    input  logic [3:0]        ex_alu_op_i,
    input  logic [DATA_W-1:0] ex_rsrc_val_i,
    input  logic              ex_is_jmp_i,
    input  logic [ADDR_W-1:0] ex_jmp_addr_i,
    input  logic              mem_read_i,
    input  logic              mem_write_i,
    input  logic [DATA_W-1:0] mem_addr_i,
    input  logic [ADDR_W-1:0] mem_sp_i,
    input  logic [ADDR_W-1:0] pc_id_i,
    input  logic [ADDR_W-1:0] pc_ex_i,
    input  logic [ADDR_W-1:0] pc_mem_i,
    input  logic [5:0]        mask_i,
    output logic              valid_o,
    output cause_e            cause_o,
    output stage_e            stage_o,
    output logic [ADDR_W-1:0] pc_o
);

    logic sp_over, sp_under, illegal_op, div_zero, imem_fault, dmem_fault;

    // Mask bit n-1 enables cause n; a masked condition never reaches the priority chain.
    assign sp_over    = mask_i[0] && (mem_sp_i > ADDR_W'(SP_MAX));
    assign sp_under   = mask_i[1] && (mem_sp_i < ADDR_W'(SP_MIN));
    assign illegal_op = mask_i[2] && (id_opcode_i > 4'(MAX_OPCODE));
    assign div_zero   = mask_i[3] && (ex_alu_op_i == 4'(DIV_OP)) && (ex_rsrc_val_i == '0);
    assign imem_fault = mask_i[4] && ex_is_jmp_i && (ex_jmp_addr_i > ADDR_W'(IMEM_MAX));
    assign dmem_fault = mask_i[5] && (mem_read_i || mem_write_i) &&
                        (mem_addr_i > DATA_W'(DMEM_MAX));

    always_comb begin
        cause_o = CauseNone;
        stage_o = StageNone;
        if (sp_over) begin
            cause_o = CauseSpOver;
            stage_o = StageMem;
        end else if (sp_under) begin
            cause_o = CauseSpUnder;
            stage_o = StageMem;
        end else if (dmem_fault) begin
            cause_o = CauseDmemFault;
            stage_o = StageMem;
        end else if (div_zero) begin
            cause_o = CauseDivZero;
            stage_o = StageEx;
        end else if (imem_fault) begin
            cause_o = CauseImemFault;
            stage_o = StageEx;
        end else if (illegal_op) begin
            cause_o = CauseIllegalOp;
            stage_o = StageId;
        end
    end

    always_comb begin
        pc_o = '0;
        unique case (stage_o)
            StageMem: pc_o = pc_mem_i;
            StageEx:  pc_o = pc_ex_i;
            StageId:  pc_o = pc_id_i;
            default:  pc_o = '0;
        endcase
    end

    assign valid_o = (stage_o != StageNone);

endmodule

// File: rtl/exception_ctrl.sv
// Pipeline exception controller: accept, flush, vector, handler/return sequencing and double-fault halt.
module exception_ctrl
    import exc_pkg::*;
#(
    parameter int                DATA_W         = 16,
    parameter int                ADDR_W         = 32,
    parameter int unsigned       SP_MIN         = DefSpMin,
    parameter int unsigned       SP_MAX         = DefSpMax,
    parameter int unsigned       IMEM_MAX       = DefImemMax,
    parameter int unsigned       DMEM_MAX       = DefDmemMax,
    parameter int unsigned       MAX_OPCODE     = DefMaxOpcode,
    parameter int unsigned       DIV_OP         = DefDivOp,
    parameter int unsigned       FLUSH_CYCLES   = DefFlushCycles,
    parameter logic [ADDR_W-1:0] HANDLER_BASE   = 32'h100,
    parameter int unsigned       HANDLER_STRIDE = DefHandlerStride
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        id_opcode_in,
    input  logic [3:0]        ex_alu_op_in,
    input  logic [DATA_W-1:0] ex_rsrc_val_in,
    input  logic              ex_is_jmp_in,
    input  logic [ADDR_W-1:0] ex_jmp_addr_in,
    input  logic              mem_read_in,
    input  logic              mem_write_in,
    input  logic [DATA_W-1:0] mem_addr_in,
    input  logic [ADDR_W-1:0] mem_sp_in,
    input  logic [ADDR_W-1:0] pc_id_in,
    input  logic [ADDR_W-1:0] pc_ex_in,
    input  logic [ADDR_W-1:0] pc_mem_in,
    input  logic              rti_in,
    input  logic              mask_we_in,
    input  logic [5:0]        mask_in,
    output logic              exception_out,
    output logic              flush_id_out,
    output logic              flush_ex_out,
    output logic              flush_mem_out,
    output logic              pc_load_out,
    output logic [ADDR_W-1:0] target_pc_out,
    output logic [ADDR_W-1:0] epc_out,
    output logic [2:0]        cause_out,
    output logic              in_handler_out,
    output logic              halted_out,
    output logic [7:0]        exc_count_out
);

    localparam int unsigned CntW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    state_e            state_q;
    cause_e            cause_q;
    logic [ADDR_W-1:0] epc_q, target_q;
    logic [7:0]        count_q;
    logic [5:0]        mask_q;
    logic [2:0]        flush_q;
    logic [CntW-1:0]   flush_cnt_q;
    logic              exc_pulse_q, pc_load_q, in_handler_q, halted_q;

    logic              det_valid;
    cause_e            det_cause;
    stage_e            det_stage;
    logic [ADDR_W-1:0] det_pc;
    logic [ADDR_W-1:0] vector_pc;
    logic              in_service;

    exc_detect #(
        .DATA_W     (DATA_W),
        .ADDR_W     (ADDR_W),
        .SP_MIN     (SP_MIN),
        .SP_MAX     (SP_MAX),
        .IMEM_MAX   (IMEM_MAX),
        .DMEM_MAX   (DMEM_MAX),
        .MAX_OPCODE (MAX_OPCODE),
        .DIV_OP     (DIV_OP)
    ) u_detect (
        .id_opcode_i   (id_opcode_in),
        .ex_alu_op_i   (ex_alu_op_in),
        .ex_rsrc_val_i (ex_rsrc_val_in),
        .ex_is_jmp_i   (ex_is_jmp_in),
        .ex_jmp_addr_i (ex_jmp_addr_in),
        .mem_read_i    (mem_read_in),
        .mem_write_i   (mem_write_in),
        .mem_addr_i    (mem_addr_in),
        .mem_sp_i      (mem_sp_in),
        .pc_id_i       (pc_id_in),
        .pc_ex_i       (pc_ex_in),
        .pc_mem_i      (pc_mem_in),
        .mask_i        (mask_q),
        .valid_o       (det_valid),
        .cause_o       (det_cause),
        .stage_o       (det_stage),
        .pc_o          (det_pc)
    );

    assign vector_pc  = HANDLER_BASE + ADDR_W'(HANDLER_STRIDE) * ADDR_W'(cause_q);
    assign in_service = (state_q == StFlush) || (state_q == StVector) ||
                        (state_q == StHandler) || (state_q == StReturn);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            cause_q      <= CauseNone;
            epc_q        <= '0;
            target_q     <= '0;
            count_q      <= '0;
            mask_q       <= '1;
            flush_q      <= '0;
            flush_cnt_q  <= '0;
            exc_pulse_q  <= 1'b0;
            pc_load_q    <= 1'b0;
            in_handler_q <= 1'b0;
            halted_q     <= 1'b0;
        end else begin
            if (mask_we_in) begin
                mask_q <= mask_in;
            end
            exc_pulse_q <= 1'b0;
            pc_load_q   <= 1'b0;
            target_q    <= '0;
            // A fault while servicing another one wins over everything, including rti_in.
            if (in_service && det_valid) begin
                state_q      <= StHalt;
                cause_q      <= CauseDouble;
                halted_q     <= 1'b1;
                flush_q      <= 3'b111;
                in_handler_q <= 1'b0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (det_valid) begin
                            state_q     <= StFlush;
                            cause_q     <= det_cause;
                            epc_q       <= det_pc;
                            exc_pulse_q <= 1'b1;
                            flush_q     <= stage_flush(det_stage);
                            flush_cnt_q <= CntW'(FLUSH_CYCLES - 1);
                            if (count_q != 8'hFF) begin
                                count_q <= count_q + 8'd1;
                            end
                        end
                    end
                    StFlush: begin
                        if (flush_cnt_q == '0) begin
                            state_q   <= StVector;
                            flush_q   <= '0;
                            pc_load_q <= 1'b1;
                            target_q  <= vector_pc;
                        end else begin
                            flush_cnt_q <= flush_cnt_q - CntW'(1);
                        end
                    end
                    StVector: begin
                        state_q      <= StHandler;
                        in_handler_q <= 1'b1;
                    end
                    StHandler: begin
                        if (rti_in) begin
                            state_q      <= StReturn;
                            in_handler_q <= 1'b0;
                            pc_load_q    <= 1'b1;
                            target_q     <= epc_q;
                        end
                    end
                    StReturn: state_q <= StIdle;
                    StHalt:   state_q <= StHalt;
                    default:  state_q <= StIdle;
                endcase
            end
        end
    end

    assign exception_out  = exc_pulse_q;
    assign flush_id_out   = flush_q[0];
    assign flush_ex_out   = flush_q[1];
    assign flush_mem_out  = flush_q[2];
    assign pc_load_out    = pc_load_q;
    assign target_pc_out  = target_q;
    assign epc_out        = epc_q;
    assign cause_out      = cause_q;
    assign in_handler_out = in_handler_q;
    assign halted_out     = halted_q;
    assign exc_count_out  = count_q;

endmodule
